// File: rtl/vec_alu_pkg.sv
// Shared constants for the vector integer ALU lane: funct6 codes, operand-type
// one-hots, element-width codes and the internal ALU operation select.
package vec_alu_pkg;

  localparam logic [5:0] F6_VADD  = 6'b000000;
  localparam logic [5:0] F6_VSUB  = 6'b000010;
  localparam logic [5:0] F6_VRSUB = 6'b000011;
  localparam logic [5:0] F6_VAND  = 6'b001001;
  localparam logic [5:0] F6_VOR   = 6'b001010;
  localparam logic [5:0] F6_VXOR  = 6'b001011;

  localparam logic [2:0] OPT_VV = 3'b001;
  localparam logic [2:0] OPT_VX = 3'b010;
  localparam logic [2:0] OPT_VI = 3'b100;

  localparam logic [2:0] VSEW_8  = 3'd0;
  localparam logic [2:0] VSEW_16 = 3'd1;
  localparam logic [2:0] VSEW_32 = 3'd2;
  localparam logic [2:0] VSEW_64 = 3'd3;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_RSUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_ZERO
  } alu_op_e;

  function automatic alu_op_e decode_funct6(input logic [5:0] f);
    case (f)
      F6_VADD:  return ALU_ADD;
      F6_VSUB:  return ALU_SUB;
      F6_VRSUB: return ALU_RSUB;
      F6_VAND:  return ALU_AND;
      F6_VOR:   return ALU_OR;
      F6_VXOR:  return ALU_XOR;
      default:  return ALU_ZERO;
    endcase
  endfunction

  function automatic logic is_subtract(input alu_op_e op);
    return (op == ALU_SUB) || (op == ALU_RSUB);
  endfunction

  // log2(SEW) for the legal element-width codes
  function automatic logic [2:0] sew_shift(input logic [2:0] vsew);
    case (vsew)
      VSEW_8:  return 3'd3;
      VSEW_16: return 3'd4;
      VSEW_32: return 3'd5;
      VSEW_64: return 3'd6;
      default: return 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/vec_alu_slice.sv
// Combinational lane-width ALU slice with carry chaining for elements wider
// than the lane datapath.
module vec_alu_slice
  import vec_alu_pkg::*;
#(
  parameter int W_LANE = 32
) (
  input  alu_op_e           op,
  input  logic [W_LANE-1:0] a,
  input  logic [W_LANE-1:0] b,
  input  logic              cin,
  output logic [W_LANE-1:0] r,
  output logic              cout
);

  logic [W_LANE:0]   sum;
  logic [W_LANE-1:0] add_x;
  logic [W_LANE-1:0] add_y;
  logic [W_LANE-1:0] and_v;
  logic [W_LANE-1:0] or_v;
  logic [W_LANE-1:0] xor_v;

  for (genvar gi = 0; gi < W_LANE; gi++) begin : g_bit
    assign and_v[gi] = b[gi] & a[gi];
    assign or_v[gi]  = b[gi] | a[gi];
    assign xor_v[gi] = b[gi] ^ a[gi];
  end

  // Subtraction is x + ~y + cin, so the slice-0 carry-in supplies the +1.
  always_comb begin
    add_x = b;
    add_y = a;
    case (op)
      ALU_SUB: begin
        add_x = b;
        add_y = ~a;
      end
      ALU_RSUB: begin
        add_x = a;
        add_y = ~b;
      end
      default: ;
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + {{W_LANE{1'b0}}, cin};
  end

  always_comb begin
    r    = '0;
    cout = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB, ALU_RSUB: begin
        r    = sum[W_LANE-1:0];
        cout = sum[W_LANE];
      end
      ALU_AND: r = and_v;
      ALU_OR:  r = or_v;
      ALU_XOR: r = xor_v;
      default: ;
    endcase
  end

endmodule

// File: rtl/vec_alu.sv
// One lane of a multi-lane vector integer ALU: walks its interleaved share of
// elements one lane-width slice per clock and builds its own vd image.
module vec_alu
  import vec_alu_pkg::*;
#(
  parameter int         VLEN       = 128,
  parameter int         LANE_WIDTH = 5,
  parameter logic [2:0] LANE_I     = 3'd0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [1:0]      nb_lanes,
  input  logic [5:0]      opcode,
  input  logic            run,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] vs2,
  input  logic [2:0]      vsew,
  input  logic [2:0]      op_type,
  output logic [VLEN-1:0] vd,
  output logic [9:0]      reg_index,
  output logic            done
);

  localparam int         W_LANE = 1 << LANE_WIDTH;
  localparam int         CW     = $clog2(VLEN / 8) + 1;
  localparam logic [2:0] LW_SH  = 3'(LANE_WIDTH);

  logic [VLEN-1:0] vd_reg;
  logic [VLEN-1:0] vd_next;
  logic [9:0]      idx_reg;
  logic            done_reg;
  logic            carry_reg;
  logic [CW-1:0]   cnt_reg;

  logic [2:0]    sew_sh;
  logic [2:0]    w_sh;
  logic [2:0]    s_sh;
  logic [CW-1:0] s_mask;
  logic [CW-1:0] slice_idx;
  logic [CW-1:0] elem_k;
  logic [9:0]    elem;
  logic [9:0]    off;
  logic [10:0]   n_cycles;
  logic          last;

  // The flat cycle count splits into (owned element k, slice s) because S is a power of two.
  assign sew_sh    = sew_shift(vsew);
  assign w_sh      = (sew_sh < LW_SH) ? sew_sh : LW_SH;
  assign s_sh      = sew_sh - w_sh;
  assign s_mask    = (CW'(1) << s_sh) - CW'(1);
  assign slice_idx = cnt_reg & s_mask;
  assign elem_k    = cnt_reg >> s_sh;
  assign elem      = 10'(LANE_I) + (10'(elem_k) << nb_lanes);
  assign off       = (elem << sew_sh) + (10'(slice_idx) << w_sh);
  assign n_cycles  = (11'(VLEN) >> w_sh) >> nb_lanes;
  assign last      = (11'(cnt_reg) == n_cycles - 11'd1);

  logic [VLEN+W_LANE-1:0] vs1_pad;
  logic [VLEN+W_LANE-1:0] vs2_pad;
  logic [63:0]            scalar_ext;
  logic [5:0]             scalar_off;
  logic [W_LANE-1:0]      op_a;
  logic [W_LANE-1:0]      op_b;

  // Zero padding keeps the W_LANE-wide select in range when W < W_LANE near the top.
  assign vs1_pad    = {{W_LANE{1'b0}}, vs1};
  assign vs2_pad    = {{W_LANE{1'b0}}, vs2};
  assign scalar_off = 6'(slice_idx) << w_sh;
  assign op_b       = vs2_pad[off +: W_LANE];

  always_comb begin
    scalar_ext = {{32{vs1[31]}}, vs1[31:0]};
    op_a       = vs1_pad[off +: W_LANE];
    case (op_type)
      OPT_VV: op_a = vs1_pad[off +: W_LANE];
      OPT_VX: begin
        scalar_ext = {{32{vs1[31]}}, vs1[31:0]};
        op_a       = scalar_ext[scalar_off +: W_LANE];
      end
      OPT_VI: begin
        scalar_ext = {{59{vs1[4]}}, vs1[4:0]};
        op_a       = scalar_ext[scalar_off +: W_LANE];
      end
      default: ;
    endcase
  end

  alu_op_e           alu_op;
  logic              alu_cin;
  logic              alu_cout;
  logic [W_LANE-1:0] slice_r;

  assign alu_op  = decode_funct6(opcode);
  assign alu_cin = (slice_idx == '0) ? is_subtract(alu_op) : carry_reg;

  vec_alu_slice #(
    .W_LANE(W_LANE)
  ) u_slice (
    .op  (alu_op),
    .a   (op_a),
    .b   (op_b),
    .cin (alu_cin),
    .r   (slice_r),
    .cout(alu_cout)
  );

  logic [6:0]      w_bits;
  logic [VLEN-1:0] lo_mask;
  logic [VLEN-1:0] wr_mask;

  assign w_bits  = 7'd1 << w_sh;
  assign lo_mask = (VLEN'(1) << w_bits) - VLEN'(1);
  assign wr_mask = lo_mask << off;
  assign vd_next = (vd_reg & ~wr_mask) | ((VLEN'(slice_r) << off) & wr_mask);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vd_reg    <= '0;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (!run) begin
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else if (!done_reg) begin
      vd_reg    <= vd_next;
      idx_reg   <= off;
      cnt_reg   <= cnt_reg + CW'(1);
      carry_reg <= alu_cout;
      done_reg  <= last;
    end
  end

  assign vd        = vd_reg;
  assign reg_index = idx_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_vec_alu.sv
// Four-lane bench for vec_alu: directed cases from the lane walk-through plus
// randomized operations checked against a whole-element reference model.
module tb_vec_alu;
  import vec_alu_pkg::*;

  localparam int VLEN = 128;
  localparam int LW   = 5;
  localparam int NL   = 4;

  logic                      clk = 1'b0;
  logic                      resetn = 1'b1;
  logic [1:0]                nb_lanes = '0;
  logic [5:0]                opcode = '0;
  logic [NL-1:0]             run_l = '0;
  logic [VLEN-1:0]           vs1 = '0;
  logic [VLEN-1:0]           vs2 = '0;
  logic [2:0]                vsew = '0;
  logic [2:0]                op_type = OPT_VV;
  logic [NL-1:0][VLEN-1:0]   vd;
  logic [NL-1:0][9:0]        reg_index;
  logic [NL-1:0]             done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    vec_alu #(
      .VLEN      (VLEN),
      .LANE_WIDTH(LW),
      .LANE_I    (3'(gi))
    ) u_dut (
      .clk      (clk),
      .resetn   (resetn),
      .nb_lanes (nb_lanes),
      .opcode   (opcode),
      .run      (run_l[gi]),
      .vs1      (vs1),
      .vs2      (vs2),
      .vsew     (vsew),
      .op_type  (op_type),
      .vd       (vd[gi]),
      .reg_index(reg_index[gi]),
      .done     (done[gi])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Whole-element reference: plain modular arithmetic on each SEW-bit element.
  function automatic logic [127:0] ref_vec(input logic [5:0] op, input logic [2:0] ot,
                                           input int sew, input logic [127:0] a1,
                                           input logic [127:0] a2);
    logic [127:0] res = '0;
    logic [63:0]  mask = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
    logic [63:0]  a;
    logic [63:0]  b;
    logic [63:0]  r;
    for (int e = 0; e < 128 / sew; e++) begin
      b = 64'(a2 >> (e * sew)) & mask;
      if (ot == OPT_VX)      a = {{32{a1[31]}}, a1[31:0]} & mask;
      else if (ot == OPT_VI) a = {{59{a1[4]}}, a1[4:0]} & mask;
      else                   a = 64'(a1 >> (e * sew)) & mask;
      case (op)
        F6_VADD:  r = b + a;
        F6_VSUB:  r = b - a;
        F6_VRSUB: r = a - b;
        F6_VAND:  r = b & a;
        F6_VOR:   r = b | a;
        F6_VXOR:  r = b ^ a;
        default:  r = 64'd0;
      endcase
      res = res | (128'(r & mask) << (e * sew));
    end
    return res;
  endfunction

  task automatic run_op(input logic [5:0] op, input logic [2:0] ot, input logic [2:0] sew_c,
                        input logic [1:0] nb, input logic [127:0] a1, input logic [127:0] a2,
                        output logic [127:0] merged);
    int sew = 8 << sew_c;
    int w   = (sew < 32) ? sew : 32;
    int n   = 1 << nb;
    int q[NL][$];
    int cyc;
    logic [127:0] expv;
    expv = ref_vec(op, ot, sew, a1, a2);
    for (int l = 0; l < n; l++)
      for (int e = l; e < 128 / sew; e += n)
        for (int s = 0; s < sew / w; s++)
          q[l].push_back(e * sew + s * w);
    cyc = q[0].size();
    opcode = op; op_type = ot; vsew = sew_c; nb_lanes = nb; vs1 = a1; vs2 = a2;
    run_l = '0;
    for (int l = 0; l < n; l++) run_l[l] = 1'b1;
    $display("op=%b type=%b sew=%0d lanes=%0d cycles=%0d vs1=%h vs2=%h", op, ot, sew, n, cyc, a1, a2);
    for (int c = 0; c < cyc; c++) begin
      @(posedge clk); #1;
      for (int l = 0; l < n; l++) begin
        chk($sformatf("reg_index l%0d c%0d", l, c), 128'(reg_index[l]), 128'(q[l][c]));
        chk($sformatf("done l%0d c%0d", l, c), 128'(done[l]), 128'(c == cyc - 1));
      end
    end
    @(posedge clk); #1;
    for (int l = 0; l < n; l++) begin
      chk($sformatf("hold done l%0d", l), 128'(done[l]), 128'(1));
      chk($sformatf("hold reg_index l%0d", l), 128'(reg_index[l]), 128'(q[l][cyc - 1]));
    end
    merged = '0;
    for (int i = 0; i < 128; i++) merged[i] = vd[(i / sew) % n][i];
    chk("merged vd vs model", merged, expv);
    run_l = '0;
    @(posedge clk); #1;
    chk("done clears on run low", 128'(done[0]), 128'(0));
  endtask

  initial begin
    logic [127:0] v1;
    logic [127:0] v2;
    logic [127:0] m;
    logic [63:0]  lo64;
    logic [7:0]   lo8;
    logic [5:0]   ops[7];
    logic [5:0]   op;
    logic [2:0]   ot;
    logic [2:0]   sc;
    logic [1:0]   nb;

    v2 = 128'h8765432112345678beefbeefabcdabcd;
    v1 = 128'habcdabcdbeefbeef1234567887654321;
    ops = '{F6_VADD, F6_VSUB, F6_VRSUB, F6_VAND, F6_VOR, F6_VXOR, 6'b100101};

    #3 resetn = 1'b0;
    #9;
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("reset vd l%0d", l), vd[l], 128'd0);
      chk($sformatf("reset reg_index l%0d", l), 128'(reg_index[l]), 128'd0);
      chk($sformatf("reset done l%0d", l), 128'(done[l]), 128'd0);
    end
    @(posedge clk); #1 resetn = 1'b1;

    run_op(F6_VAND, OPT_VV, 3'd0, 2'd2, v1, v2, m);
    chk("vand sew8 const", m, 128'h83450301122416681224166883450301);
    run_op(F6_VAND, OPT_VV, 3'd1, 2'd2, v1, v2, m);
    chk("vand sew16 const", m, 128'h83450301122416681224166883450301);
    run_op(F6_VAND, OPT_VV, 3'd2, 2'd2, v1, v2, m);
    chk("vand sew32 const", m, 128'h83450301122416681224166883450301);
    run_op(F6_VAND, OPT_VV, 3'd3, 2'd1, v1, v2, m);
    chk("vand sew64 const", m, 128'h83450301122416681224166883450301);

    run_op(F6_VADD, OPT_VX, 3'd2, 2'd2, {v1[127:32], 32'hFFFF_FFFF}, v2, m);
    chk("vadd vx sew32 const", m, 128'h8765432012345677beefbeeeabcdabcc);
    run_op(F6_VADD, OPT_VX, 3'd3, 2'd1, {v1[127:32], 32'hFFFF_FFFF}, v2, m);
    chk("vadd vx sew64 const", m, 128'h8765432112345677beefbeefabcdabcc);

    run_op(F6_VADD, OPT_VV, 3'd3, 2'd1, {64'd0, 64'd1},
           {64'h8765432112345678, 64'h00000000FFFFFFFF}, m);
    lo64 = m[63:0];
    chk("carry crossing", 128'(lo64), 128'h0000000100000000);

    run_op(F6_VADD, OPT_VI, 3'd0, 2'd2, 128'h0F, {16{8'hFF}}, m);
    lo8 = m[7:0];
    chk("vadd vi byte", 128'(lo8), 128'h0E);

    opcode = F6_VXOR; op_type = OPT_VV; vsew = 3'd0; nb_lanes = 2'd2; vs1 = v1; vs2 = v2;
    run_l = '1;
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    $display("async reset asserted mid-run");
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("midrun reset vd l%0d", l), vd[l], 128'd0);
      chk($sformatf("midrun reset reg_index l%0d", l), 128'(reg_index[l]), 128'd0);
      chk($sformatf("midrun reset done l%0d", l), 128'(done[l]), 128'd0);
    end
    run_l = '0;
    @(posedge clk); #1 resetn = 1'b1;
    run_op(F6_VXOR, OPT_VV, 3'd0, 2'd2, v1, v2, m);

    for (int t = 0; t < 24; t++) begin
      op = ops[$urandom_range(0, 6)];
      ot = 3'b001 << $urandom_range(0, 2);
      sc = 3'($urandom_range(0, 3));
      nb = (sc == 3'd3) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 2));
      run_op(op, ot, sc, nb, {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, m);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vec_alu.md
Name: vec_alu

Overview:
- One lane of a multi-lane RISC-V vector integer ALU.
- Up to 2^nb_lanes identical instances share vs1/vs2 and each owns an interleaved subset of elements.
- While run is high, each clock processes one element, or one lane-width slice of an element, and writes it into the lane's own VLEN-wide vd image.
- reg_index reports the bit offset just written. done flags that the lane's share is complete.

Parameters:
- VLEN, 128: vector register width in bits (power of 2, 64..512).
- LANE_WIDTH, 5: log2 of lane datapath width; W_LANE = 1<<LANE_WIDTH bits (3..6).
- LANE_I, 0 (3 bits): index of this lane among active lanes.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- nb_lanes  in  2  log2 of number of active lanes (N = 1<<nb_lanes); stable while run=1.
- opcode  in  6  funct6 of the vector instruction.
- run  in  1  lane enable; high for the whole operation.
- vs1  in  VLEN  vector operand 1 (VV), or scalar in [31:0] (VX), or imm in [4:0] (VI).
- vs2  in  VLEN  vector operand 2.
- vsew  in  3  element width code; SEW = 8<<vsew; codes 0..3 only.
- op_type  in  3  one-hot: 001 VV, 010 VX, 100 VI.
- vd  out  VLEN  registered result image; only slices written by this lane are meaningful.
- reg_index  out  10  bit offset of the slice written on the last processing edge.
- done  out  1  registered; high once the lane's last slice is written.

Behaviour:
- Reset (async, resetn=0): vd=0, reg_index=0, done=0, internal counters=0, carry=0.
- Slice width W = min(SEW, W_LANE). Slices per element S = SEW/W. Elements per register E = VLEN/SEW.
- The lane owns elements e = LANE_I + k*N, k = 0,1,... while e < E.
- Per owned element, slices are taken low to high. Lane cycle count C = (VLEN/W) >> nb_lanes.
- Slice offset: reg_index = e*SEW + s*W.
- Edge with run=0: counters<=0, carry<=0, done<=0; vd and reg_index hold.
- Edge with run=1 and done=0:
  - Compute slice r = f(a,b) on W bits and write vd[off +: W] = r; all other vd bits hold.
  - Update reg_index <= off.
  - Advance the counters.
  - Set done <= 1 if this was slice C-1, else 0.
- Edge with run=1 and done=1: hold everything; no further writes.
- Operands: b = vs2[off +: W].
  - VV: a = vs1[off +: W].
  - VX: a = slice s of vs1[31:0] sign-extended to SEW.
  - VI: a = slice s of vs1[4:0] sign-extended to SEW.
- Opcodes:
  - 000000 vadd: b+a.
  - 000010 vsub: b-a.
  - 000011 vrsub: a-b.
  - 001001 vand: b&a.
  - 001010 vor: b|a.
  - 001011 vxor: b^a.
  - Any other opcode writes zero.
- Multi-slice arithmetic (S>1):
  - Slice 0 uses carry-in 0 for add and 1 for subtract, with subtract done as x + ~y + 1.
  - Carry-out is registered and feeds slice s+1 of the same element.
  - Results are modular in SEW bits; no saturation or flags.
- A lane with LANE_I >= N must simply never see run=1; no internal check.

Decomposition:
- Shared package: funct6 opcode constants, op_type one-hot constants, vsew codes.
- One natural sub-module, vec_alu_slice: combinational W_LANE-bit ALU with carry-in, carry-out and op select.
- Slice selection, counters, vd update and done live in vec_alu.

Test Plan:
- Vectors: vs2=8765432112345678beefbeefabcdabcd; vs1=abcdabcdbeefbeef1234567887654321; LANE_WIDTH=5, 4 lanes.
- vand, VV, vsew=0, nb_lanes=2, run 4 cycles:
  - done low after cycles 1-3 and high after cycle 4.
  - Lane0 reg_index sequence 0,32,64,96.
  - Merged vd = 83450301122416681224166883450301.
- vand, VV, vsew=1/2/3:
  - nb_lanes=2, 2 cycles (16b); nb_lanes=2, 1 cycle (32b); nb_lanes=1, 2 cycles (64b).
  - Merged vd identical to above in each case.
  - 64b lane0 reg_index 0 then 32.
- vadd, VX, vs1[31:0]=FFFFFFFF (-1):
  - vsew=2: merged vd = 8765432012345677beefbeeeabcdabcc.
  - vsew=3: low element beefbeefabcdabcc, high element 8765432112345677.
- Carry crossing, vadd VV vsew=3, vs2 element0 = 00000000FFFFFFFF, vs1 element0 = 1 -> vd[63:0] = 0000000100000000.
- vadd, VI, imm=01111, vsew=0, vs2 byte FF -> 0E.
- resetn pulsed low mid-run -> vd, reg_index and done read 0 immediately.
- After run drops and is reasserted, the sequence restarts from slice 0 with done=0.
